output_deskew_buffer: RTL and testbench

- Sits directly downstream of the 8x8 weight-stationary systolic array.
- The array emits each result row skewed: column j of a row appears j enabled cycles after column 0.
- This block delays each column so all ARRAY_SIZE results of a row line up, then queues whole rows in a FIFO and drains them to the consumer with a valid/ready handshake.
- It also gives the array controller backpressure (almost_full) and a sticky overflow flag.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/row_fifo.sv | 70 +++++++
 rtl/output_deskew_buffer.sv | 111 +++++++++++
 tb/tb_output_deskew_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Types and defaults shared by the systolic array and its output stages.
package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 8;
    localparam int DEF_ACC_WIDTH  = 32;

    typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;
    typedef acc_t [DEF_ARRAY_SIZE-1:0]       row_t;

    // Occupancy at which the array controller must be throttled.
    function automatic int af_level(input int depth, input int margin);
        return depth - margin;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous show-ahead FIFO holding whole aligned result rows.
module row_fifo
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      push,
    input  logic                                      pop,
    input  logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] din,
    output logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] dout,
    output logic [$clog2(DEPTH+1)-1:0]                count,
    output logic                                      full,
    output logic                                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push_s = push && (!full || do_pop_s);

    // Row storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/output_deskew_buffer.sv
// Realigns skewed systolic-array result rows and queues them for a
// valid/ready consumer, with backpressure and a sticky drop flag.
module output_deskew_buffer
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        enable,
    input  logic                                        in_valid,
    input  logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] c_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]             count,
    output logic                                        almost_full,
    output logic                                        overflow,
    input  logic                                        clear_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [CW-1:0] AF_LEVEL = CW'(af_level(FIFO_DEPTH, AF_MARGIN));

    logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] aligned_s;
    logic [ARRAY_SIZE-2:0]                vpipe_r;
    logic                                 push_s;
    logic                                 pop_s;
    logic                                 drop_s;
    logic                                 full_s;
    logic                                 empty_s;
    logic                                 overflow_r;

    // Column j arrives j cycles late, so it is held back ARRAY_SIZE-1-j cycles.
    for (genvar j = 0; j < ARRAY_SIZE-1; j++) begin : g_col
        localparam int STAGES = ARRAY_SIZE-1-j;
        logic [STAGES-1:0][ACC_WIDTH-1:0] dly_r;

        // Enable-gated delay line for this column.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dly_r <= '0;
            end else if (enable) begin
                dly_r[0] <= c_in[j];
                for (int k = 1; k < STAGES; k++) begin
                    dly_r[k] <= dly_r[k-1];
                end
            end else begin
                dly_r <= dly_r;
            end
        end

        assign aligned_s[j] = dly_r[STAGES-1];
    end
    assign aligned_s[ARRAY_SIZE-1] = c_in[ARRAY_SIZE-1];

    // Row tag follows column 0 to the point where the row is complete.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vpipe_r <= '0;
        end else if (enable) begin
            vpipe_r[0] <= in_valid;
            for (int k = 1; k < ARRAY_SIZE-1; k++) begin
                vpipe_r[k] <= vpipe_r[k-1];
            end
        end else begin
            vpipe_r <= vpipe_r;
        end
    end

    assign push_s = enable && vpipe_r[ARRAY_SIZE-2];
    assign pop_s  = out_ready && !empty_s;
    assign drop_s = push_s && full_s && !pop_s;

    row_fifo #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ACC_WIDTH  (ACC_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (aligned_s),
        .dout  (out_data),
        .count (count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign out_valid   = !empty_s;
    assign almost_full = (count >= AF_LEVEL);
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Self-checking bench: randomized and directed rows against a queue-based model.
module tb_output_deskew_buffer;
    import systolic_pkg::*;

    localparam int AS    = DEF_ARRAY_SIZE;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst, enable, in_valid, out_ready, clear_overflow;
    row_t          c_in, out_data;
    logic          out_valid, almost_full, overflow;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    output_deskew_buffer #(
        .ARRAY_SIZE (AS),
        .ACC_WIDTH  (DEF_ACC_WIDTH),
        .FIFO_DEPTH (DEPTH),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .in_valid       (in_valid),
        .c_in           (c_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .count          (count),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int   checks   = 0;
    int   failures = 0;

    // Model: rows are planned by enabled-cycle index of their tag; column j of a
    // row is presented j enabled cycles after the tag and the row completes
    // AS-1 enabled cycles after the tag.
    row_t mq[$];
    bit   m_ovf;
    int   tags[$];
    int   ecnt;
    row_t hist[64];
    row_t plan[int];
    row_t sent[17];

    function automatic logic [CW+2:0] exp_flags();
        return {mq.size() != 0, CW'(mq.size()), mq.size() >= DEPTH-AFM, m_ovf};
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < AS; j++) r[j] = acc_t'($urandom);
        return r;
    endfunction

    task automatic step();
        row_t built;
        bit   push, pop, drop;
        push = 1'b0;
        drop = 1'b0;
        in_valid = 1'b0;
        if (enable) begin
            for (int j = 0; j < AS; j++) begin
                if (plan.exists(ecnt-j)) c_in[j] = plan[ecnt-j][j];
                else                     c_in[j] = acc_t'($urandom);
            end
            in_valid = plan.exists(ecnt);
        end
        pop = out_ready && mq.size() != 0;
        if (!rst) begin
            mq.delete();
            tags.delete();
            m_ovf = 1'b0;
        end else begin
            if (enable) begin
                hist[ecnt%64] = c_in;
                if (in_valid) tags.push_back(ecnt);
                if (tags.size() != 0 && tags[0] + AS - 1 == ecnt) begin
                    for (int j = 0; j < AS; j++) built[j] = hist[(tags[0]+j)%64][j];
                    void'(tags.pop_front());
                    push = 1'b1;
                end
                ecnt++;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(built);
                else                   drop = 1'b1;
            end
            if (drop)                m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_single_row();
        row_t r;
        for (int j = 0; j < AS; j++) r[j] = acc_t'(100 + j);
        plan[ecnt] = r;
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++; if ({out_valid, count, almost_full, overflow} !== exp_flags()) begin failures++; $display("FAIL single_flags cyc=%0d got=%b exp=%b", c, {out_valid, count, almost_full, overflow}, exp_flags()); end
            checks++; if (out_valid !== (c == 8)) begin failures++; $display("FAIL single_valid_cycle cyc=%0d got=%b exp=%b", c, out_valid, c == 8); end
            if (c == 8) begin
                checks++; if (out_data !== r) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data, r); end
            end
            if (c == 9) begin
                checks++; if (count !== '0) begin failures++; $display("FAIL single_count_drained got=%0d exp=0", count); end
            end
        end
    endtask

    task automatic test_enable_gaps();
        row_t r;
        for (int j = 0; j < AS; j++) r[j] = acc_t'(100 + j);
        plan[ecnt] = r;
        out_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            enable = !((c-1) >= 3 && (c-1) <= 5);
            step();
            checks++; if ({out_valid, count, almost_full, overflow} !== exp_flags()) begin failures++; $display("FAIL gaps_flags cyc=%0d got=%b exp=%b", c, {out_valid, count, almost_full, overflow}, exp_flags()); end
            checks++; if (out_valid !== (c == 11)) begin failures++; $display("FAIL gaps_valid_cycle cyc=%0d got=%b exp=%b", c, out_valid, c == 11); end
            if (c == 11) begin
                checks++; if (out_data !== r) begin failures++; $display("FAIL gaps_data got=%h exp=%h", out_data, r); end
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        row_t r [4];
        int   base;
        base = ecnt;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < AS; j++) r[k][j] = acc_t'(k*10 + j);
            plan[base+k] = r[k];
        end
        out_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            checks++; if (out_valid !== (c >= 8 && c <= 11)) begin failures++; $display("FAIL b2b_valid_cycle cyc=%0d got=%b exp=%b", c, out_valid, c >= 8 && c <= 11); end
            if (c >= 8 && c <= 11) begin
                checks++; if (out_data !== r[c-8]) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, out_data, r[c-8]); end
            end
        end
    endtask

    task automatic test_fill_full();
        int base;
        base = ecnt;
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            sent[k] = rand_row();
            plan[base+k] = sent[k];
        end
        for (int c = 1; c <= 28; c++) begin
            step();
            checks++; if ({out_valid, count, almost_full, overflow} !== exp_flags()) begin failures++; $display("FAIL fill_flags cyc=%0d got=%b exp=%b", c, {out_valid, count, almost_full, overflow}, exp_flags()); end
            if (c == 19) begin
                checks++; if (almost_full !== 1'b1 || count !== CW'(12)) begin failures++; $display("FAIL fill_af_at_12 count=%0d af=%b exp count=12 af=1", count, almost_full); end
            end
        end
        checks++; if (count !== CW'(16) || overflow !== 1'b1) begin failures++; $display("FAIL fill_saturate count=%0d ovf=%b exp count=16 ovf=1", count, overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== sent[k]) begin failures++; $display("FAIL fill_drain row=%0d v=%b got=%h exp=%h", k, out_valid, out_data, sent[k]); end
            step();
        end
        checks++; if (count !== '0 || overflow !== 1'b1) begin failures++; $display("FAIL fill_drained count=%0d ovf=%b exp count=0 ovf=1", count, overflow); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_clear_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        int base;
        base = ecnt;
        for (int k = 0; k < 17; k++) begin
            sent[k] = rand_row();
            plan[base+k] = sent[k];
        end
        for (int c = 1; c <= 26; c++) begin
            out_ready = ((c-1) == 23);
            step();
            checks++; if ({out_valid, count, almost_full, overflow} !== exp_flags()) begin failures++; $display("FAIL fpp_flags cyc=%0d got=%b exp=%b", c, {out_valid, count, almost_full, overflow}, exp_flags()); end
        end
        checks++; if (count !== CW'(16) || overflow !== 1'b0) begin failures++; $display("FAIL fpp_count count=%0d ovf=%b exp count=16 ovf=0", count, overflow); end
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            checks++; if (out_data !== sent[k]) begin failures++; $display("FAIL fpp_drain row=%0d got=%h exp=%h", k, out_data, sent[k]); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        row_t r;
        r = rand_row();
        plan[ecnt] = r;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0 || count !== '0) begin failures++; $display("FAIL rstmid_cleared v=%b count=%0d exp v=0 count=0", out_valid, count); end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ghost_row cyc=%0d got=%b exp=0", c, out_valid); end
        end
        r = rand_row();
        plan[ecnt] = r;
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++; if (out_valid !== (c == 8)) begin failures++; $display("FAIL rstmid_new_valid cyc=%0d got=%b exp=%b", c, out_valid, c == 8); end
            if (c == 8) begin
                checks++; if (out_data !== r) begin failures++; $display("FAIL rstmid_new_data got=%h exp=%h", out_data, r); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            enable         = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) == 0);
            clear_overflow = ($urandom_range(0, 19) == 0);
            rst            = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 1) == 0 && !plan.exists(ecnt)) plan[ecnt] = rand_row();
            step();
            checks++; if ({out_valid, count, almost_full, overflow} !== exp_flags()) begin failures++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, {out_valid, count, almost_full, overflow}, exp_flags()); end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, mq[0]); end
            end
        end
        rst = 1'b1;
        clear_overflow = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_overflow = 1'b0;
        c_in = '0;
        m_ovf = 1'b0;
        ecnt = 0;
        #1;
        test_reset();
        test_single_row();
        test_enable_gaps();
        test_back_to_back();
        test_fill_full();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
